// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared definitions for the universal shift register.
//                Holds the mode encoding and the shift-op classifier
//                that the top level and the frame counter both use.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_pkg;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ASR  = 3'b101;
    localparam logic [2:0] M_LOAD = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    // Every mode from SHL to ASR moves the register by one bit position
    // and therefore counts toward a frame.
    function automatic logic is_shift(input logic [2:0] mode);
        return (mode >= M_SHL) && (mode <= M_ASR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_counter.sv
`default_nettype none
// ============================================================================
//  Module      : frame_counter
//  Description : Counts shift operations and pulses done for one cycle
//                after every WIDTH-th shift. The wrapping edge also
//                starts the next frame.
//  Ports       : clk   - clock
//                reset - synchronous active-high reset
//                clr   - restart the frame (load/clear), no pulse
//                step  - one shift operation happened this cycle
//                done  - registered one-cycle frame-complete pulse
//  Revision    : 1.0  initial release
// ============================================================================
module frame_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic step,
    output logic done
);

    localparam int             CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic          r_done;

    // clr and step are decoded from different modes, so they never
    // occur together; clr is still given priority for clarity.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (step) begin
            if (r_cnt == c_last) begin
                r_cnt  <= '0;
                r_done <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_done <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shift_reg
//  Description : WIDTH-bit universal shift register with hold, logical
//                shifts, rotates, arithmetic shift right, parallel load
//                and clear, serial taps at both ends, and a frame pulse
//                after every WIDTH shift operations.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                en              - operation enable (0 = hold)
//                mode[2:0]       - operation select
//                sin_l / sin_r   - serial inputs for left / right shifts
//                pdin[WIDTH-1:0] - parallel load data
//                q[WIDTH-1:0]    - register contents
//                sout_l / sout_r - q[WIDTH-1] / q[0]
//                frame_done      - one-cycle frame-complete pulse
//  Revision    : 1.0  initial release
// ============================================================================
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             frame_done
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_step;
    logic             w_clr;

    always_comb begin
        w_q_next = r_q;
        if (en) begin
            case (mode)
                M_HOLD:  w_q_next = r_q;
                M_SHL:   w_q_next = {r_q[WIDTH-2:0], sin_l};
                M_SHR:   w_q_next = {sin_r, r_q[WIDTH-1:1]};
                M_ROL:   w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                M_ROR:   w_q_next = {r_q[0], r_q[WIDTH-1:1]};
                M_ASR:   w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                M_LOAD:  w_q_next = pdin;
                M_CLR:   w_q_next = '0;
                default: w_q_next = r_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign w_step = en && is_shift(mode);
    assign w_clr  = en && ((mode == M_LOAD) || (mode == M_CLR));

    frame_counter #(
        .WIDTH (WIDTH)
    ) u_frame_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .step  (w_step),
        .done  (frame_done)
    );

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_univ_shift_reg
//  Description : Directed, table-driven bench for univ_shift_reg (WIDTH=8)
//                plus a hand-written back-to-back rotate sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_univ_shift_reg;

    localparam int WIDTH = 8;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] SHL  = 3'b001;
    localparam logic [2:0] SHR  = 3'b010;
    localparam logic [2:0] ROL  = 3'b011;
    localparam logic [2:0] ROR  = 3'b100;
    localparam logic [2:0] ASR  = 3'b101;
    localparam logic [2:0] LOAD = 3'b110;
    localparam logic [2:0] CLR  = 3'b111;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] pdin;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             frame_done;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic       sl;
        logic       sr;
        logic [7:0] pdin;
        logic [7:0] eq;
        logic       efd;
    } vec_t;

    vec_t vecs[$];

    univ_shift_reg #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .sin_l      (sin_l),
        .sin_r      (sin_r),
        .pdin       (pdin),
        .q          (q),
        .sout_l     (sout_l),
        .sout_r     (sout_r),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic [2:0] m,
                       input logic sl, input logic sr, input logic [7:0] pd,
                       input logic [7:0] eq, input logic efd);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sl = sl; v.sr = sr;
        v.pdin = pd; v.eq = eq; v.efd = efd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst; en = v.en; mode = v.mode;
        sin_l = v.sl; sin_r = v.sr; pdin = v.pdin;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int idx,
                             input logic [7:0] eq, input logic efd);
        logic [7:0] e;
        e = eq;
        chk({tag, ".q"},          idx, 32'(q),          32'(e));
        chk({tag, ".sout_l"},     idx, 32'(sout_l),     32'(e[7]));
        chk({tag, ".sout_r"},     idx, 32'(sout_r),     32'(e[0]));
        chk({tag, ".frame_done"}, idx, 32'(frame_done), 32'(efd));
    endtask

    initial begin
        logic [7:0] model;

        reset = 1'b1; en = 1'b0; mode = HOLD;
        sin_l = 1'b0; sin_r = 1'b0; pdin = '0;

        // reset, reset beats load, then load
        add(1, 0, HOLD, 0, 0, 8'h00, 8'h00, 0);
        add(1, 1, LOAD, 0, 0, 8'hA5, 8'h00, 0);
        add(0, 1, LOAD, 0, 0, 8'hA5, 8'hA5, 0);
        // serial shift left 1,0,1,0,0,0,1,0
        add(0, 1, CLR,  0, 0, 8'h00, 8'h00, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h01, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'h02, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h05, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'h0A, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'h14, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'h28, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h51, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'hA2, 1);
        add(0, 1, HOLD, 1, 1, 8'hFF, 8'hA2, 0);
        // rotates and arithmetic shift
        add(0, 1, LOAD, 0, 0, 8'h81, 8'h81, 0);
        add(0, 1, ROL,  0, 0, 8'h00, 8'h03, 0);
        add(0, 1, ROR,  0, 0, 8'h00, 8'h81, 0);
        add(0, 1, LOAD, 0, 0, 8'h90, 8'h90, 0);
        add(0, 1, ASR,  0, 0, 8'h00, 8'hC8, 0);
        add(0, 1, ASR,  0, 0, 8'h00, 8'hE4, 0);
        add(0, 1, LOAD, 0, 0, 8'h42, 8'h42, 0);
        add(0, 1, ASR,  1, 1, 8'h00, 8'h21, 0);
        // SHR with pause (en=0 must ignore mode, including LOAD)
        add(0, 1, CLR,  0, 0, 8'h00, 8'h00, 0);
        add(0, 1, SHR,  0, 1, 8'h00, 8'h80, 0);
        add(0, 1, SHR,  0, 1, 8'h00, 8'hC0, 0);
        add(0, 1, SHR,  0, 1, 8'h00, 8'hE0, 0);
        add(0, 1, SHR,  0, 1, 8'h00, 8'hF0, 0);
        add(0, 0, SHR,  0, 1, 8'h00, 8'hF0, 0);
        add(0, 0, LOAD, 0, 1, 8'h55, 8'hF0, 0);
        add(0, 0, CLR,  0, 1, 8'h00, 8'hF0, 0);
        add(0, 1, SHR,  0, 1, 8'h00, 8'hF8, 0);
        add(0, 1, SHR,  0, 1, 8'h00, 8'hFC, 0);
        add(0, 1, SHR,  0, 1, 8'h00, 8'hFE, 0);
        add(0, 1, SHR,  0, 1, 8'h00, 8'hFF, 1);
        add(0, 1, HOLD, 0, 0, 8'h00, 8'hFF, 0);
        // 5 SHL, LOAD restarts the frame, then 8 SHL
        add(0, 1, CLR,  0, 0, 8'h00, 8'h00, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h01, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h03, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h07, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h0F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h1F, 0);
        add(0, 1, LOAD, 0, 0, 8'h00, 8'h00, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h01, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h03, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h07, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h0F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h1F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h3F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h7F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'hFF, 1);
        add(0, 1, HOLD, 0, 0, 8'h00, 8'hFF, 0);
        // 3 SHL then reset mid-frame; next 8 shifts form a fresh frame
        add(0, 1, SHL,  0, 0, 8'h00, 8'hFE, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'hFC, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'hF8, 0);
        add(1, 1, SHL,  1, 0, 8'h00, 8'h00, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h01, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h03, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h07, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h0F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h1F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h3F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h7F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'hFF, 1);
        // back-to-back frames: 16 continuous SHL
        add(0, 1, SHL,  0, 0, 8'h00, 8'hFE, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'hFC, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'hF8, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'hF0, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'hE0, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'hC0, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'h80, 0);
        add(0, 1, SHL,  0, 0, 8'h00, 8'h00, 1);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h01, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h03, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h07, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h0F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h1F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h3F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'h7F, 0);
        add(0, 1, SHL,  1, 0, 8'h00, 8'hFF, 1);
        add(0, 1, HOLD, 0, 0, 8'h00, 8'hFF, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check_all("vec", i, vecs[i].eq, vecs[i].efd);
        end

        // Hand-written: 24 continuous rotates after a load, mixing ROL
        // and ROR; pulses must land on every 8th shift.
        begin
            vec_t v;
            v.rst = 0; v.en = 1; v.mode = LOAD; v.sl = 0; v.sr = 0;
            v.pdin = 8'h35; v.eq = 8'h35; v.efd = 0;
            apply(v);
            check_all("rot_load", 0, 8'h35, 1'b0);
            model = 8'h35;
            for (int i = 0; i < 24; i++) begin
                v.mode = (i % 3 == 2) ? ROR : ROL;
                v.pdin = 8'h00;
                if (v.mode == ROL) model = {model[6:0], model[7]};
                else               model = {model[0], model[7:1]};
                apply(v);
                check_all("rot", i, model, (i % 8) == 7);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
